// File: rtl/snake_frame_reader.sv
// Raster-scans the snake grid into a cell framebuffer once per draw window.
// Optional macro SNAKE_BORDER_EN paints the outer ring of cells with colour 3'b111.
module snake_frame_reader #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        isDrawing,
  input  logic [31:0] rstage,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [9:0]  wr_addr,
  output logic [2:0]  wr_color,
  output logic        frame_done,
  output logic        overrun,
  output logic [31:0] stage_q
);

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          r_state, w_next;
  logic            r_draw_q;
  logic            r_overrun;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [31:0]     r_stage;

  logic w_start, w_accept, w_x_end, w_y_end, w_last, w_abort;

  assign w_start  = isDrawing && !r_draw_q;
  assign w_accept = (r_state == SCAN) && wr_ready;
  assign w_x_end  = (r_x == XW'(GRID_W - 1));
  assign w_y_end  = (r_y == YW'(GRID_H - 1));
  assign w_last   = w_accept && w_x_end && w_y_end;

  // Completion wins over a window closing on the same cycle.
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_next = SCAN;
      SCAN: begin
        if (w_last) w_next = DONE;
        else if (!isDrawing) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_draw_q  <= 1'b0;
      r_overrun <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_stage   <= '0;
    end else begin
      r_draw_q <= isDrawing;
      if (w_abort) r_overrun <= 1'b1;
      if (r_state == IDLE && w_start) begin
        r_stage <= rstage;
        r_x     <= '0;
        r_y     <= '0;
      end else if (w_accept) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign wr_valid   = (r_state == SCAN);
  assign frame_done = (r_state == DONE);
  assign overrun    = r_overrun;
  assign stage_q    = r_stage;
  assign wr_addr    = 10'(int'(r_y) * GRID_W + int'(r_x));

`ifdef SNAKE_BORDER_EN
  logic w_border;
  // Gated by SCAN so the idle colour stays at its reset value.
  assign w_border = (r_state == SCAN) &&
                    ((r_x == '0) || w_x_end || (r_y == '0) || w_y_end);
  assign wr_color = w_border ? 3'b111 : r_stage[2:0];
`else
  assign wr_color = r_stage[2:0];
`endif

endmodule

// File: doc/snake_frame_reader.md
SNAKE_FRAME_READER -- requirements
Module: snake_frame_reader

Interface
REQ-001 Parameter GRID_W, default 32, grid width in cells.
REQ-002 Parameter GRID_H, default 24, grid height in cells; GRID_W*GRID_H SHALL be at most 1024.
REQ-003 Port clock, input, 1, sole clock; all logic SHALL be on the rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port isDrawing, input, 1, draw-window enable from the game-state block; high means a frame may be drawn.
REQ-006 Port rstage, input, 32, current game stage from the game-state block.
REQ-007 Port wr_valid, output, 1, cell-write request valid.
REQ-008 Port wr_ready, input, 1, framebuffer accepts the request this cycle.
REQ-009 Port wr_addr, output, 10, cell address, row-major, y*GRID_W+x.
REQ-010 Port wr_color, output, 3, cell colour code.
REQ-011 Port frame_done, output, 1, one-cycle pulse when a full frame has been written.
REQ-012 Port overrun, output, 1, sticky flag: a draw window closed before its frame completed.
REQ-013 Port stage_q, output, 32, stage value latched for the current or last frame.

Function
REQ-014 States SHALL be IDLE, SCAN and DONE.
REQ-015 A registered copy of isDrawing (draw_q) SHALL be kept; start = isDrawing && !draw_q.
REQ-016 IDLE->SCAN on start; in the same edge, stage_q<=rstage and x=y=0.
REQ-017 In SCAN, wr_valid SHALL be 1; wr_addr and wr_color SHALL stay stable until wr_valid && wr_ready.
REQ-018 On acceptance, x SHALL increment; at x=GRID_W-1, x wraps to 0 and y increments.
REQ-019 Acceptance of cell (GRID_W-1, GRID_H-1) SHALL cause SCAN->DONE; wr_valid SHALL be 0 from the next cycle.
REQ-020 DONE SHALL last exactly one cycle with frame_done=1, then return to IDLE.
REQ-021 In SCAN with isDrawing=0 and no last-cell acceptance: SCAN->IDLE, overrun<=1, no frame_done, wr_valid=0 from the next cycle.
REQ-022 If isDrawing falls in the same cycle the last cell is accepted, completion SHALL take priority: DONE, frame_done pulse, overrun unchanged.
REQ-023 A rising edge of isDrawing seen in DONE or SCAN SHALL be ignored; a new frame starts only from IDLE.
REQ-024 Interior cell colour SHALL be stage_q[2:0]; rstage changes during SCAN SHALL NOT affect output.
REQ-025 Throughput SHALL be one cell per cycle with wr_ready held high: GRID_W*GRID_H cycles from the first wr_valid to the last acceptance.
REQ-026 overrun SHALL stay at 1 until reset.

Reset
REQ-027 Reset SHALL force the state to IDLE; wr_valid, frame_done and overrun to 0; wr_addr, wr_color, x and y to 0; stage_q to 0; draw_q to 0.
REQ-028 Reset SHALL take priority over all other events and abort any scan without asserting frame_done.
REQ-029 If isDrawing is already high on the first cycle after reset, the reset value draw_q=0 SHALL make that cycle a start.

Configuration
REQ-030 Macro SNAKE_BORDER_EN: when defined, cells with x=0, x=GRID_W-1, y=0 or y=GRID_H-1 SHALL use wr_color=3'b111.
REQ-031 Without SNAKE_BORDER_EN, all cells SHALL use stage_q[2:0], and no border logic SHALL be present.

Verification
REQ-032 Scenario: reset, rstage=2, isDrawing 0->1, wr_ready=1 -> 768 writes to addresses 0..767, colour 2 (7 on the border if SNAKE_BORDER_EN), frame_done pulse one cycle after address 767, overrun=0.
REQ-033 Scenario: wr_ready toggles every cycle -> no address skipped or repeated; address and colour held while wr_ready=0; 1536 cycles to complete.
REQ-034 Scenario: isDrawing drops after 100 acceptances -> wr_valid=0 the next cycle, overrun=1, no frame_done; the next rising edge restarts at address 0.
REQ-035 Scenario: isDrawing drops in the cycle address 767 is accepted -> frame_done=1, overrun=0.
REQ-036 Scenario: rstage changes 2->5 mid-scan -> all remaining interior colours stay 2; the next frame uses 5.
REQ-037 Scenario: reset asserted mid-scan at address 300 -> all outputs are at reset values the next cycle, and frame_done never pulses.
